// File: rtl/alu_pkg.sv
// Shared types and constants for the shared-ALU scheduler and its ALU datapath.
//   op_sel_e      : ALU operation encoding (ADD, SUB, AND, OR)
//   ALU_W         : ALU operand/result width
//   sched_state_e : scheduler FSM states
package alu_pkg;

    localparam int unsigned ALU_W = 8;

    typedef enum logic [1:0] {
        OpAdd = 2'b00,
        OpSub = 2'b01,
        OpAnd = 2'b10,
        OpOr  = 2'b11
    } op_sel_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StResp = 2'b10
    } sched_state_e;

endpackage

// File: rtl/alu.sv
// Team 8-bit ALU datapath, purely combinational.
//   a_i, b_i   : operands
//   op_sel_i   : 00 ADD, 01 SUB, 10 AND, 11 OR
//   y_o        : result, modulo 2^ALU_W
//   ovf_o      : signed (two's complement) overflow for ADD/SUB, 0 for logic ops
module alu
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a_i,
    input  logic [ALU_W-1:0] b_i,
    input  logic [1:0]       op_sel_i,
    output logic [ALU_W-1:0] y_o,
    output logic             ovf_o
);

    always_comb begin
        y_o   = '0;
        ovf_o = 1'b0;
        unique case (op_sel_e'(op_sel_i))
            OpAdd: begin
                y_o   = a_i + b_i;
                ovf_o = (a_i[ALU_W-1] == b_i[ALU_W-1]) && (y_o[ALU_W-1] != a_i[ALU_W-1]);
            end
            OpSub: begin
                y_o   = a_i - b_i;
                ovf_o = (a_i[ALU_W-1] != b_i[ALU_W-1]) && (y_o[ALU_W-1] != a_i[ALU_W-1]);
            end
            OpAnd: y_o = a_i & b_i;
            OpOr:  y_o = a_i | b_i;
            default: begin
                y_o   = '0;
                ovf_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i     : request vector
//   ptr_i     : highest-priority index; search runs ptr_i, ptr_i+1, ... modulo NUM_REQ
//   grant_o   : one-hot grant, zero when nothing requests
//   idx_o     : encoded index of the granted requester (0 when none)
//   valid_o   : a grant was issued
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               valid_o
);

    logic [ID_W-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(ptr_i) + k) % NUM_REQ);
            if (!valid_o && req_i[cand]) begin
                valid_o       = 1'b1;
                idx_o         = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one ALU between NUM_REQ requesters with round-robin arbitration.
// A granted request is registered (IDLE), evaluated by the ALU for one cycle (EXEC),
// and the tagged result is held until the consumer accepts it (RESP).
//   clk, rst_n    : clock, asynchronous active-low reset
//   req_valid_i   : per-requester request valid
//   req_ready_o   : per-requester accept, one-hot or zero, only in IDLE
//   req_a_i/b_i   : packed operands, requester i at [8i+7:8i]
//   req_op_i      : packed op select, requester i at [2i+1:2i]
//   rsp_valid_o   : result valid, held until rsp_ready_i
//   rsp_id_o      : owning requester of the result
//   rsp_y_o       : ALU result
//   rsp_ovf_o     : ALU overflow flag
//   busy_o        : FSM not idle
//   op_count_o    : completed operations, saturating
module alu_rr_scheduler
    import alu_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*ALU_W-1:0] req_a_i,
    input  logic [NUM_REQ*ALU_W-1:0] req_b_i,
    input  logic [NUM_REQ*2-1:0]     req_op_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [ID_W-1:0]          rsp_id_o,
    output logic [ALU_W-1:0]         rsp_y_o,
    output logic                     rsp_ovf_o,
    output logic                     busy_o,
    output logic [15:0]              op_count_o
);

    sched_state_e     state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ALU_W-1:0] op_a_q, op_a_d;
    logic [ALU_W-1:0] op_b_q, op_b_d;
    logic [1:0]       op_sel_q, op_sel_d;
    logic [ID_W-1:0]  op_id_q, op_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [ALU_W-1:0] rsp_y_q, rsp_y_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic [15:0]      op_count_q, op_count_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_valid;
    logic [ALU_W-1:0]   alu_y;
    logic               alu_ovf;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i   (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    alu u_alu (
        .a_i      (op_a_q),
        .b_i      (op_b_q),
        .op_sel_i (op_sel_q),
        .y_o      (alu_y),
        .ovf_o    (alu_ovf)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_sel_d    = op_sel_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_y_d     = rsp_y_q;
        rsp_ovf_d   = rsp_ovf_q;
        op_count_d  = op_count_q;
        req_ready_o = '0;

        unique case (state_q)
            StIdle: begin
                // ready is only raised toward a valid requester, so a grant is a handshake
                if (arb_valid) begin
                    req_ready_o = arb_grant;
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (arb_grant[i]) begin
                            op_a_d   = req_a_i[ALU_W*i +: ALU_W];
                            op_b_d   = req_b_i[ALU_W*i +: ALU_W];
                            op_sel_d = req_op_i[2*i +: 2];
                        end
                    end
                    op_id_d  = arb_idx;
                    rr_ptr_d = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    state_d  = StExec;
                end
            end
            StExec: begin
                rsp_y_d     = alu_y;
                rsp_ovf_d   = alu_ovf;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    if (op_count_q != 16'hFFFF) begin
                        op_count_d = op_count_q + 16'd1;
                    end
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_sel_q    <= '0;
            op_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_y_q     <= '0;
            rsp_ovf_q   <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_sel_q    <= op_sel_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_y_q     <= rsp_y_d;
            rsp_ovf_q   <= rsp_ovf_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_y_o     = rsp_y_q;
    assign rsp_ovf_o   = rsp_ovf_q;
    assign busy_o      = (state_q != StIdle);
    assign op_count_o  = op_count_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler (NUM_REQ = 4).
module tb_alu_rr_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [7:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_y;
    logic        rsp_ovf;
    logic        busy;
    logic [15:0] op_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, AND = 2'b10, OR = 2'b11;

    alu_rr_scheduler #(
        .NUM_REQ (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_op_i    (req_op),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_y_o     (rsp_y),
        .rsp_ovf_o   (rsp_ovf),
        .busy_o      (busy),
        .op_count_o  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [1:0] op);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
        req_op[2*i +: 2] = op;
    endtask

    // Full three-cycle transaction with rsp_ready held high.
    task automatic serve(input string tag, input logic [3:0] g, input logic [1:0] id,
                         input logic [7:0] y, input logic ovf);
        #1;
        chk({tag, "/ready"}, 32'(req_ready), 32'(g));
        chk({tag, "/idle"}, 32'(busy), 32'd0);
        tick();
        chk({tag, "/exec_busy"}, 32'(busy), 32'd1);
        chk({tag, "/exec_nvalid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "/exec_ready"}, 32'(req_ready), 32'd0);
        tick();
        chk({tag, "/valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "/id"}, 32'(rsp_id), 32'(id));
        chk({tag, "/y"}, 32'(rsp_y), 32'(y));
        chk({tag, "/ovf"}, 32'(rsp_ovf), 32'(ovf));
        chk({tag, "/resp_ready"}, 32'(req_ready), 32'd0);
        tick();
        exp_cnt++;
        chk({tag, "/done_nvalid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "/count"}, 32'(op_count), 32'(exp_cnt));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "/rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "/rsp_id"}, 32'(rsp_id), 32'd0);
        chk({tag, "/rsp_y"}, 32'(rsp_y), 32'd0);
        chk({tag, "/rsp_ovf"}, 32'(rsp_ovf), 32'd0);
        chk({tag, "/busy"}, 32'(busy), 32'd0);
        chk({tag, "/req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "/op_count"}, 32'(op_count), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        #3;
        chk_reset_vals("por");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single requester 0: 12 + 34 = 46
        set_req(0, 8'h12, 8'h34, ADD);
        req_valid = 4'b0001;
        serve("single0", 4'b0001, 2'd0, 8'h46, 1'b0);
        req_valid = '0;
        tick();

        // Reset during EXEC: rr_ptr is 1, so requester 1 is granted
        set_req(1, 8'h11, 8'h22, ADD);
        req_valid = 4'b0010;
        #1;
        chk("rstexec/ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        chk("rstexec/busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rstexec");
        exp_cnt = 0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstexec/no_pulse", 32'(rsp_valid), 32'd0);
        end
        // rr_ptr is back at 0, only requester 2 valid
        set_req(2, 8'h40, 8'h05, SUB);
        req_valid = 4'b0100;
        serve("after_rstexec", 4'b0100, 2'd2, 8'h3B, 1'b0);
        req_valid = '0;

        // Reset during RESP: rr_ptr is 3
        rsp_ready = 1'b0;
        set_req(3, 8'h33, 8'h44, OR);
        req_valid = 4'b1000;
        #1;
        chk("rstresp/ready", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        tick();
        chk("rstresp/valid", 32'(rsp_valid), 32'd1);
        chk("rstresp/y", 32'(rsp_y), 32'h77);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rstresp");
        exp_cnt = 0;
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstresp/no_pulse", 32'(rsp_valid), 32'd0);
        end

        // Four requesters, rr_ptr = 0: grants 0,1,2,3 back to back
        set_req(0, 8'hF0, 8'h3C, AND);
        set_req(1, 8'h0F, 8'hF0, OR);
        set_req(2, 8'h10, 8'h01, SUB);
        set_req(3, 8'h01, 8'h01, ADD);
        req_valid = 4'b1111;
        serve("all4/g0", 4'b0001, 2'd0, 8'h30, 1'b0);
        serve("all4/g1", 4'b0010, 2'd1, 8'hFF, 1'b0);
        serve("all4/g2", 4'b0100, 2'd2, 8'h0F, 1'b0);
        serve("all4/g3", 4'b1000, 2'd3, 8'h02, 1'b0);
        req_valid = '0;

        // Wrap arithmetic, one requester at a time following rr_ptr 0..3
        set_req(0, 8'h00, 8'h01, SUB);
        req_valid = 4'b0001;
        serve("wrap/sub", 4'b0001, 2'd0, 8'hFF, 1'b0);
        set_req(1, 8'hFF, 8'h01, ADD);
        req_valid = 4'b0010;
        serve("wrap/add", 4'b0010, 2'd1, 8'h00, 1'b0);
        set_req(2, 8'h7F, 8'h01, ADD);
        req_valid = 4'b0100;
        serve("ovf/add", 4'b0100, 2'd2, 8'h80, 1'b1);
        set_req(3, 8'h80, 8'h01, SUB);
        req_valid = 4'b1000;
        serve("ovf/sub", 4'b1000, 2'd3, 8'h7F, 1'b1);

        // Fairness: move rr_ptr to 2, then 1 and 3 held valid
        set_req(1, 8'h05, 8'h03, ADD);
        set_req(3, 8'h0A, 8'h50, OR);
        req_valid = 4'b0010;
        serve("fair/pre", 4'b0010, 2'd1, 8'h08, 1'b0);
        req_valid = 4'b1010;
        serve("fair/g3a", 4'b1000, 2'd3, 8'h5A, 1'b0);
        serve("fair/g1a", 4'b0010, 2'd1, 8'h08, 1'b0);
        serve("fair/g3b", 4'b1000, 2'd3, 8'h5A, 1'b0);
        serve("fair/g1b", 4'b0010, 2'd1, 8'h08, 1'b0);
        req_valid = '0;

        // Backpressure on requester 2 (rr_ptr = 2)
        rsp_ready = 1'b0;
        set_req(2, 8'h20, 8'h22, ADD);
        req_valid = 4'b0100;
        #1;
        chk("bp/ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b1111;
        tick();
        chk("bp/valid", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp/hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp/hold_y", 32'(rsp_y), 32'h42);
            chk("bp/hold_id", 32'(rsp_id), 32'd2);
            chk("bp/hold_ready", 32'(req_ready), 32'd0);
            chk("bp/hold_busy", 32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        tick();
        exp_cnt++;
        chk("bp/accept_nvalid", 32'(rsp_valid), 32'd0);
        chk("bp/accept_count", 32'(op_count), 32'(exp_cnt));
        chk("bp/keep_y", 32'(rsp_y), 32'h42);
        chk("bp/keep_id", 32'(rsp_id), 32'd2);
        chk("bp/next_grant", 32'(req_ready), 32'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one instance of the team's 8-bit ALU (A, B, OP_SEL -> Y, OVF) between NUM_REQ requesters.
- Uses round-robin arbitration with valid/ready handshakes on both the request and response sides.
- Registers the operands, runs the combinational ALU for one cycle, then holds the tagged result until the consumer accepts it.
- Sits between the agent-generated datapath clients and the shared ALU.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the requester index. Derived; not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  in  NUM_REQ*8  packed operand A; requester i is at [8i+7:8i].
- req_b  in  NUM_REQ*8  packed operand B.
- req_op  in  NUM_REQ*2  packed OP_SEL: 00 ADD, 01 SUB, 10 AND, 11 OR.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_y  out  8  ALU result.
- rsp_ovf  out  1  ALU overflow flag, passed through unchanged.
- busy  out  1  high whenever the FSM is not IDLE.
- op_count  out  16  completed-operation counter.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE, rr_ptr=0, op_count=0.
  - rsp_valid=0, rsp_id=0, rsp_y=0, rsp_ovf=0.
  - busy=0, req_ready=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant g is the first i with req_valid[i]=1, searching i=rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[g]=1 combinationally; all other req_ready bits are 0.
  - If no req_valid is set, req_ready=0 and the FSM stays in IDLE.
  - On the handshake (req_valid[g] & req_ready[g]):
    - latch req_a, req_b and req_op slice g into op_a, op_b, op_sel;
    - latch g into op_id;
    - rr_ptr <= (g+1) mod NUM_REQ;
    - go to EXEC.
- EXEC (one cycle):
  - The ALU is driven from op_a, op_b, op_sel.
  - At the clock edge: rsp_y<=Y, rsp_ovf<=OVF, rsp_id<=op_id, rsp_valid<=1; go to RESP.
  - req_ready=0.
- RESP:
  - rsp_valid and the rsp_* outputs hold stable until rsp_ready=1. req_ready=0.
  - On rsp_valid & rsp_ready: rsp_valid<=0, op_count<=op_count+1 (saturates at 16'hFFFF), go to IDLE.
  - rsp_y, rsp_id and rsp_ovf keep their last values after acceptance.
- Latency and throughput:
  - Request handshake at edge T gives rsp_valid=1 from T+2.
  - With rsp_ready held high, a new request handshake is possible at T+3. Peak rate is one operation per 3 cycles.
- Fairness: a requester that holds req_valid is granted within NUM_REQ grants.
- Boundary conditions:
  - Requests that deassert before their grant are dropped without side effects.
  - req_valid changing during EXEC or RESP is ignored.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - ALU arithmetic is modulo 2^8. The block adds no width extension.
  - rst_n asserted mid-operation aborts at once to the reset values. An in-flight result is lost and is never presented.
- Invariants: rsp_valid never drops without the handshake, and $onehot0(req_ready) always holds.

Decomposition:
- Shared package alu_pkg:
  - op_sel_e enum (ADD=2'b00, SUB, AND, OR);
  - ALU_W=8;
  - sched_state_e (IDLE, EXEC, RESP).
- One natural sub-module, rr_arbiter: parameterised NUM_REQ; inputs req vector and ptr; outputs one-hot grant and encoded index. It is purely combinational.
- The scheduler instantiates the existing alu datapath unchanged.

Test Plan:
- Single requester 0: A=8'h12, B=8'h34, OP=ADD -> req_ready[0] in the same cycle; rsp_valid two cycles after the handshake with rsp_y=8'h46, rsp_id=0; op_count becomes 1.
- Requesters 0..3 all valid with distinct ops (0: AND 8'hF0/8'h3C, 1: OR 8'h0F/8'hF0, 2: SUB 8'h10/8'h01, 3: ADD 8'h01/8'h01), rsp_ready=1 -> grants in order 0,1,2,3; results 8'h30, 8'hFF, 8'h0F, 8'h02; 3 cycles per operation.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_y, rsp_id and rsp_valid remain stable, req_ready stays 0, busy=1; accepted on the first cycle rsp_ready=1.
- Fairness and wrap: requesters 1 and 3 held valid continuously, rr_ptr starting at 2 -> grants 3,1,3,1; rr_ptr wraps 3 -> 0.
- Wrap arithmetic: SUB A=8'h00, B=8'h01 -> rsp_y=8'hFF. ADD 8'hFF + 8'h01 -> rsp_y=8'h00. rsp_ovf equals the ALU OVF output in both cases.
- Reset during EXEC, and separately during RESP -> all outputs return to their reset values asynchronously; no rsp_valid pulse afterwards; op_count=0; the next request is served normally.
